montador_programa: RTL and testbench
====================================

Name: montador_programa

Overview:
- Encoder/loader: takes instruction fields (opcode, registers, immediate, jump target) over a valid/ready handshake.
- Packs each instruction into the 10-bit machine word that the control decoder consumes.
- Writes each word sequentially into the 32-entry instruction memory.
- On a finish request, pads all unused addresses with RST words, so the program memory is never left partially undefined.

Parameters:
PROG_DEPTH  32  number of instruction-memory words; must be ≤ 2**ADDR_W
ADDR_W  5  instruction address width (matches 5-bit jump target)
PAD_WORD  10'b0111000000  word written to unused addresses (RST)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: clear address/count, enter ACCEPT
in_valid  in  1  instruction fields valid
in_ready  out  1  block accepts fields this cycle
opcode  in  4  instruction opcode
rd  in  2  destination register (source for STORE)
ra  in  2  source register A
rb  in  2  source register B
imm  in  4  immediate / data-memory address
target  in  ADDR_W  jump target
fin  in  1  pulse: pad remainder and finish
mem_we  out  1  instruction-memory write enable
mem_addr  out  ADDR_W  write address
mem_data  out  10  encoded machine word
count  out  ADDR_W+1  instructions written (excludes padding)
done  out  1  memory fully written
erro  out  1  sticky: in_valid while not accepting after start

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - mem_we=0, mem_addr=0, mem_data=0, count=0, done=0, erro=0, in_ready=0.
- States and transitions:
  - IDLE: start → ACCEPT.
  - ACCEPT: in_ready=1.
    - in_valid=1: register encoded word → WRITE.
    - else fin=1 → PAD.
    - If in_valid and fin are both high, the instruction wins; fin is ignored and must be re-pulsed.
  - WRITE: mem_we=1 for exactly one cycle with the registered mem_addr/mem_data; count+1.
    - If mem_addr==PROG_DEPTH-1 → DONE.
    - Else mem_addr+1 → ACCEPT.
  - PAD: mem_we=1 and mem_data=PAD_WORD every cycle from the current address through PROG_DEPTH-1; then → DONE. count is unchanged.
  - DONE: done=1, in_ready=0, mem_we=0.
- start in any state: abort the current activity, mem_addr=0, count=0, done=0, erro=0, → ACCEPT next cycle. No write occurs in the start cycle.
- erro sets when in_valid=1 in WRITE, PAD or DONE, or in IDLE after at least one start. It clears only on start or reset.
- Latency: handshake at cycle n → mem_we at n+1. Max throughput is 1 instruction per 2 cycles.
- mem_addr and mem_data hold their last values when mem_we=0.
- Encoding, bits [9:6]=opcode:
  - 0000 ADD, 0001 SUB: [5:4]=rd, [3:2]=ra, [1:0]=rb.
  - 0010 ADDi, 0011 SUBi: [5:4]=rd, [3:0]=imm (rd is also source A).
  - 0100 MUL, 0101 DIV, 1000 MOV, 1011 INC, 1100 DEC: [5:4]=rd, [3:2]=ra, [1:0]=00.
  - 0110 CLR, 1111 read-nibble: [5:4]=rd, [3:0]=0000.
  - 0111 RST: [5:0]=0.
  - 1001 JMP, 1010 JZ: [5]=0, [4:0]=target.
  - 1101 LOAD: [5:4]=rd, [3:0]=imm.
  - 1110 STORE: [5:4]=rd (source), [3:0]=imm.
  - Unused fields are forced to 0 regardless of their input values.
- Boundaries:
  - fin at mem_addr=0: PROG_DEPTH pad writes.
  - fin after the last word has been written is unreachable, because the block is already in DONE.
  - Reset mid-WRITE or mid-PAD: mem_we drops immediately (asynchronously).

Test Plan:
- Encode four instructions:
  - Stimulus: reset, start; send ADD rd=1 ra=2 rb=3; ADDi rd=2 imm=5; JMP target=17; STORE rd=3 imm=9.
  - Required: writes 0x01B@0, 0x0A5@1, 0x251@2, 0x3B9@3; count=4; each mem_we exactly 1 cycle after its handshake.
- Padding:
  - Stimulus: after the first test, pulse fin.
  - Required: 28 consecutive writes of 0x1C0 at addresses 4..31, then done=1, count=4.
- Fill to capacity:
  - Stimulus: start; send 32 MOV rd=0 ra=1 rb=3.
  - Required: 32 writes of 0x204 with rb masked to 00; done=1 after address 31; a 33rd in_valid is not accepted and sets erro=1.
- Simultaneous in_valid and fin:
  - Stimulus: both high in ACCEPT with INC rd=2 ra=2.
  - Required: 0x2E8 written, no padding; state returns to ACCEPT.
- Abort:
  - Stimulus: pulse start during PAD at address 10.
  - Required: no further pad writes; mem_addr=0, count=0, erro=0; next instruction is written at address 0.
- Async reset:
  - Stimulus: rst_n low mid-WRITE, between clock edges.
  - Required: mem_we=0 and all outputs at reset values immediately; in_ready=0 until start.

Source files
------------

// File: rtl/montador_programa_if.sv
// Load-side bus of the program loader: instruction fields with valid/ready,
// start/fin control pulses, and the instruction-memory write port plus status.
interface montador_programa_if #(
    parameter int ADDR_W = 5
) ();
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        opcode;
    logic [1:0]        rd;
    logic [1:0]        ra;
    logic [1:0]        rb;
    logic [3:0]        imm;
    logic [ADDR_W-1:0] target;
    logic              fin;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [9:0]        mem_data;
    logic [ADDR_W:0]   count;
    logic              done;
    logic              erro;

    modport master (
        output start, in_valid, opcode, rd, ra, rb, imm, target, fin,
        input  in_ready, mem_we, mem_addr, mem_data, count, done, erro
    );

    modport slave (
        input  start, in_valid, opcode, rd, ra, rb, imm, target, fin,
        output in_ready, mem_we, mem_addr, mem_data, count, done, erro
    );
endinterface

// File: rtl/montador_programa.sv
// Program loader: packs instruction fields into 10-bit machine words, writes them
// sequentially into instruction memory and pads the unused tail with RST words.
module montador_programa #(
    parameter int         PROG_DEPTH = 32,
    parameter int         ADDR_W     = 5,
    parameter logic [9:0] PAD_WORD   = 10'b0111000000
) (
    input  logic               clk,
    input  logic               rst_n,
    montador_programa_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCEPT = 3'd1;
    localparam logic [2:0] WRITE  = 3'd2;
    localparam logic [2:0] PAD    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [9:0]        data_q, data_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              erro_q, erro_d;

    logic       use_rd, use_ra, use_rb, use_imm, use_tgt;
    logic [4:0] tgt5;
    logic [9:0] enc_word;

    assign tgt5 = 5'(bus.target);

    // Each opcode enables only the fields it carries; everything else packs as zero.
    always_comb begin
        use_rd  = 1'b0;
        use_ra  = 1'b0;
        use_rb  = 1'b0;
        use_imm = 1'b0;
        use_tgt = 1'b0;
        case (bus.opcode)
            4'b0000, 4'b0001: begin
                use_rd = 1'b1;
                use_ra = 1'b1;
                use_rb = 1'b1;
            end
            4'b0010, 4'b0011, 4'b1101, 4'b1110: begin
                use_rd  = 1'b1;
                use_imm = 1'b1;
            end
            4'b0100, 4'b0101, 4'b1000, 4'b1011, 4'b1100: begin
                use_rd = 1'b1;
                use_ra = 1'b1;
            end
            4'b0110, 4'b1111: use_rd  = 1'b1;
            4'b1001, 4'b1010: use_tgt = 1'b1;
            default: ;
        endcase
        enc_word = {bus.opcode, 6'b000000}
                 | (use_rd  ? {4'b0000, bus.rd, 4'b0000}   : 10'd0)
                 | (use_ra  ? {6'b000000, bus.ra, 2'b00}   : 10'd0)
                 | (use_rb  ? {8'b00000000, bus.rb}        : 10'd0)
                 | (use_imm ? {6'b000000, bus.imm}         : 10'd0)
                 | (use_tgt ? {5'b00000, tgt5}             : 10'd0);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        erro_d  = erro_q;
        if (bus.start) begin
            state_d = ACCEPT;
            addr_d  = '0;
            count_d = '0;
            erro_d  = 1'b0;
        end else begin
            if (bus.in_valid && (state_q == WRITE || state_q == PAD || state_q == DONE)) begin
                erro_d = 1'b1;
            end
            case (state_q)
                ACCEPT: begin
                    // An instruction beats a simultaneous fin; fin must be re-pulsed.
                    if (bus.in_valid) begin
                        data_d  = enc_word;
                        state_d = WRITE;
                    end else if (bus.fin) begin
                        data_d  = PAD_WORD;
                        state_d = PAD;
                    end
                end
                WRITE: begin
                    count_d = count_q + CNT_ONE;
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = ACCEPT;
                    end
                end
                PAD: begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
            erro_q  <= erro_d;
        end
    end

    // start suppresses the write (and the handshake) of the cycle it arrives in.
    assign bus.mem_we   = (state_q == WRITE || state_q == PAD) && !bus.start;
    assign bus.in_ready = (state_q == ACCEPT) && !bus.start;
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = data_q;
    assign bus.count    = count_q;
    assign bus.done     = (state_q == DONE);
    assign bus.erro     = erro_q;
endmodule

// File: tb/tb_montador_programa.sv
// Randomized bench for the program loader: expected words, addresses and counts
// come from a transaction-level model of the loader's rules.
module tb_montador_programa;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    montador_programa_if #(.ADDR_W(5)) bus ();

    montador_programa #(
        .PROG_DEPTH(32),
        .ADDR_W    (5),
        .PAD_WORD  (10'h1C0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int we_seen = 0;
    int we_exp = 0;
    int m_addr = 0;
    int m_count = 0;

    always @(negedge clk) begin
        #2;
        if (bus.mem_we === 1'b1) we_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference packing: bits [9:6] opcode, lower six bits by instruction format.
    function automatic logic [9:0] ref_enc(input logic [3:0] op, input logic [1:0] rd,
                                           input logic [1:0] ra, input logic [1:0] rb,
                                           input logic [3:0] imm, input logic [4:0] tgt);
        logic [5:0] low;
        case (op)
            4'h0, 4'h1:                   low = {rd, ra, rb};
            4'h2, 4'h3, 4'hD, 4'hE:       low = {rd, imm};
            4'h4, 4'h5, 4'h8, 4'hB, 4'hC: low = {rd, ra, 2'b00};
            4'h6, 4'hF:                   low = {rd, 4'b0000};
            4'h9, 4'hA:                   low = {1'b0, tgt};
            default:                      low = 6'b000000;
        endcase
        return {op, low};
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        m_addr  = 0;
        m_count = 0;
    endtask

    task automatic send(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                        input logic [1:0] rb, input logic [3:0] imm, input logic [4:0] tgt,
                        input bit with_fin);
        logic [9:0] w;
        int i;
        w = ref_enc(op, rd, ra, rb, imm, tgt);
        i = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && i < 20) begin
            @(negedge clk);
            i++;
        end
        chk("in_ready", 32'(bus.in_ready), 32'd1);
        bus.opcode = op; bus.rd = rd; bus.ra = ra; bus.rb = rb;
        bus.imm = imm; bus.target = tgt;
        bus.in_valid = 1'b1;
        bus.fin = with_fin;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.fin = 1'b0;
        @(negedge clk);
        chk("we_latency", 32'(bus.mem_we), 32'd1);
        chk("wr_addr", 32'(bus.mem_addr), 32'(m_addr));
        chk("wr_data", 32'(bus.mem_data), 32'(w));
        $display("txn op=%h addr=%0d word=%03h", op, m_addr, w);
        we_exp++;
        m_count++;
        if (m_addr < 31) m_addr++;
        @(negedge clk);
        chk("we_one_cycle", 32'(bus.mem_we), 32'd0);
        chk("count", 32'(bus.count), 32'(m_count));
    endtask

    task automatic rnd_send();
        send(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 2'($urandom),
             4'($urandom), 5'($urandom), 1'b0);
    endtask

    task automatic pulse_fin();
        @(negedge clk);
        bus.fin = 1'b1;
        @(posedge clk);
        #1 bus.fin = 1'b0;
    endtask

    task automatic check_pad(input int a);
        @(negedge clk);
        chk("pad_we", 32'(bus.mem_we), 32'd1);
        chk("pad_addr", 32'(bus.mem_addr), 32'(a));
        chk("pad_data", 32'(bus.mem_data), 32'h1C0);
        $display("txn pad addr=%0d", a);
        we_exp++;
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.fin = 1'b0;
        bus.opcode = '0; bus.rd = '0; bus.ra = '0; bus.rb = '0;
        bus.imm = '0; bus.target = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we", 32'(bus.mem_we), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_data", 32'(bus.mem_data), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_erro", 32'(bus.erro), 32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("idle_erro", 32'(bus.erro), 32'd0);

        // Four directed instructions, then padding of 4..31
        pulse_start();
        send(4'h0, 2'd1, 2'd2, 2'd3, 4'd0, 5'd0, 1'b0);
        send(4'h2, 2'd2, 2'd0, 2'd0, 4'd5, 5'd0, 1'b0);
        send(4'h9, 2'd0, 2'd0, 2'd0, 4'd0, 5'd17, 1'b0);
        send(4'hE, 2'd3, 2'd0, 2'd0, 4'd9, 5'd0, 1'b0);
        pulse_fin();
        for (int a = 4; a < 32; a++) check_pad(a);
        @(negedge clk);
        chk("pad_done", 32'(bus.done), 32'd1);
        chk("pad_we_off", 32'(bus.mem_we), 32'd0);
        chk("pad_count", 32'(bus.count), 32'd4);
        chk("done_ready", 32'(bus.in_ready), 32'd0);

        // Fill to capacity with MOV, random (masked) rb/imm/target
        pulse_start();
        for (int k = 0; k < 32; k++)
            send(4'h8, 2'd0, 2'd1, 2'($urandom), 4'($urandom), 5'($urandom), 1'b0);
        chk("full_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("full_erro", 32'(bus.erro), 32'd1);
        chk("full_we", 32'(bus.mem_we), 32'd0);
        chk("full_count", 32'(bus.count), 32'd32);

        // in_valid and fin together: instruction wins, back to ACCEPT
        pulse_start();
        chk("start_clr_erro", 32'(bus.erro), 32'd0);
        send(4'hB, 2'd2, 2'd2, 2'($urandom), 4'($urandom), 5'($urandom), 1'b1);
        chk("simul_ready", 32'(bus.in_ready), 32'd1);
        chk("simul_done", 32'(bus.done), 32'd0);

        // Abort during PAD at address 10
        pulse_start();
        for (int k = 0; k < 7; k++) rnd_send();
        pulse_fin();
        for (int a = 7; a < 10; a++) begin
            check_pad(a);
            if (a == 8) bus.in_valid = 1'b1;
            if (a == 9) bus.in_valid = 1'b0;
        end
        @(negedge clk);
        chk("pad_erro", 32'(bus.erro), 32'd1);
        chk("abort_addr_pre", 32'(bus.mem_addr), 32'd10);
        #1 bus.start = 1'b1;
        #1 chk("abort_we", 32'(bus.mem_we), 32'd0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        m_addr = 0;
        m_count = 0;
        chk("abort_addr", 32'(bus.mem_addr), 32'd0);
        chk("abort_count", 32'(bus.count), 32'd0);
        chk("abort_erro", 32'(bus.erro), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", 32'(bus.mem_we), 32'd0);
        end
        rnd_send();
        rnd_send();

        // Asynchronous reset in the middle of a WRITE cycle
        @(negedge clk);
        bus.opcode = 4'h1; bus.rd = 2'd3; bus.ra = 2'd1; bus.rb = 2'd2;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        #1 chk("pre_rst_we", 32'(bus.mem_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(bus.mem_we), 32'd0);
        chk("arst_addr", 32'(bus.mem_addr), 32'd0);
        chk("arst_data", 32'(bus.mem_data), 32'd0);
        chk("arst_count", 32'(bus.count), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_erro", 32'(bus.erro), 32'd0);
        chk("arst_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.in_ready), 32'd0);
        end
        pulse_start();
        rnd_send();

        @(negedge clk);
        #3;
        chk("we_total", 32'(we_seen), 32'(we_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
